seq_match_ctrl: RTL and testbench
=================================

// Module: seq_match_ctrl
// PURPOSE
//  Run-time programmable serial pattern-match controller; supersedes fixed-pattern detector FSMs.
//  Latches a pattern config, accepts a framed serial bit stream over valid/ready, flags each match
//  Mealy-style, counts matches, and signals frame completion. Sits between a bit source and status/IRQ logic.
// PARAMETERS
//  MAX_LEN   8    maximum pattern length in bits (2..16)
//  CNT_W     8    width of match counter
//  FRAME_W   8    width of frame-length field
//  TIMEOUT   64   stall limit in cycles (used only with SEQ_MATCH_TIMEOUT_EN)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  cfg_we       in   1        config write strobe (honoured in IDLE only)
//  cfg_pattern  in   MAX_LEN  pattern; bit[cfg_len-1] = first bit received, bit[0] = last
//  cfg_len      in   5        pattern length, legal 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping detection, 0 = non-overlapping
//  start        in   1        begin a frame (IDLE only)
//  frame_len    in   FRAME_W  bits in frame, sampled with start; 0 = illegal
//  abort        in   1        terminate scan immediately
//  bit_valid    in   1        serial bit present
//  bit_in       in   1        serial bit
//  bit_ready    out  1        controller accepts a bit this cycle
//  z            out  1        match flag, combinational, same cycle as final bit's handshake
//  match_cnt    out  CNT_W    matches in current/last frame, saturating
//  busy         out  1        high in SCAN
//  done         out  1        one-cycle pulse at frame completion
//  err          out  1        one-cycle pulse on illegal request
// BEHAVIOUR
//  Reset: state=IDLE; bit_ready, z, busy, done, err = 0; match_cnt = 0; config regs = 0; history cleared.
//  States: IDLE -> SCAN -> DONE -> IDLE; abort path SCAN -> IDLE.
//  IDLE: cfg_we latches pattern/len/overlap. start with cfg_len in 1..MAX_LEN and frame_len!=0
//   -> SCAN next cycle, match_cnt:=0, history cleared, remaining:=frame_len. Otherwise err pulse, stay IDLE.
//   cfg_we and start same cycle: new config is used by that frame.
//  SCAN: bit_ready=1, busy=1. Accept = bit_valid & bit_ready. On accept: bit shifted into history
//   (MAX_LEN bits), fill count increments (saturating at MAX_LEN), remaining decrements.
//  z = accept & (fill+1 >= cfg_len) & (low cfg_len bits of {history,bit_in} == cfg_pattern low bits).
//  On z: match_cnt+1, saturating at 2^CNT_W-1. If cfg_overlap=0, fill count clears (history reused never).
//  Last bit (remaining==1 on accept): z still evaluated for that bit; -> DONE.
//  DONE: done=1 for exactly one cycle, bit_ready=0; -> IDLE. match_cnt held until next legal start.
//  abort in SCAN: -> IDLE next cycle, no done, no z that cycle (abort overrides accept), match_cnt held.
//  abort outside SCAN: ignored. cfg_we outside IDLE: ignored, err pulse. start outside IDLE: ignored, err pulse.
//  Reset mid-scan: immediate return to reset values; partial frame discarded.
//  Latency: z combinational (0 cycles); match_cnt updates 1 cycle after the matching handshake.
// CONFIGURATION
//  SEQ_MATCH_TIMEOUT_EN defined: stall counter runs in SCAN, clears on each accept; reaching TIMEOUT
//   consecutive cycles without accept -> err pulse, state -> IDLE, no done.
//  Undefined: no stall counter; SCAN waits indefinitely for bit_valid.
// TESTING
//  1. len=5 pat=5'b11101 overlap=1 frame_len=9, stream 1,1,1,0,1,1,1,0,1 -> z on bits 5 and 9, match_cnt=2, done once.
//  2. Same stream, overlap=0 -> z on bit 5 only, match_cnt=1.
//  3. start with cfg_len=0 or frame_len=0 -> err 1-cycle pulse, busy stays 0, match_cnt unchanged.
//  4. bit_valid toggled with gaps during frame of 6 bits, pattern 3'b101 on 1,0,1,0,1,1 -> z on bits 3,5; done after 6th accept.
//  5. abort after 4 bits of 9 -> busy falls next cycle, no done, match_cnt keeps partial value; rst_n low mid-scan -> all outputs 0.
//  6. With SEQ_MATCH_TIMEOUT_EN, TIMEOUT=64: hold bit_valid=0 64 cycles in SCAN -> err pulse, return to IDLE; undefined -> stays SCAN.

Source files
------------

// File: rtl/seq_match_if.sv
// Handshake/config bundle between a serial bit source and seq_match_ctrl.
// master drives config, frame control and bits; slave is the controller.
interface seq_match_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int FRAME_W = 8
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [4:0]         cfg_len;
    logic               cfg_overlap;
    logic               start;
    logic [FRAME_W-1:0] frame_len;
    logic               abort;
    logic               bit_valid;
    logic               bit_in;
    logic               bit_ready;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len,
               abort, bit_valid, bit_in,
        input  bit_ready, z, match_cnt, busy, done, err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len,
               abort, bit_valid, bit_in,
        output bit_ready, z, match_cnt, busy, done, err
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// Run-time programmable serial pattern-match controller with framed valid/ready input.
// Optional SEQ_MATCH_TIMEOUT_EN: abandon a scan after TIMEOUT cycles without an accepted bit.
module seq_match_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int FRAME_W = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_match_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [4:0]         len_q;
    logic               overlap_q;
    // Only MAX_LEN-1 past bits are kept; the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist_q;
    logic [4:0]         fill_q;
    logic [FRAME_W-1:0] remain_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic               bit_ready, busy, done, z, accept, err_set;
    logic               legal_start;
    logic [4:0]         eff_len;
    logic [MAX_LEN-1:0] window, mask;
    logic               hit, filled;

`ifdef SEQ_MATCH_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q;
`endif

    // A config write in the same cycle as start defines the frame being started.
    assign eff_len     = bus.cfg_we ? bus.cfg_len : len_q;
    assign legal_start = (eff_len != 5'd0) && (eff_len <= 5'(MAX_LEN)) &&
                         (bus.frame_len != '0);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign window = {hist_q, bus.bit_in};
    assign hit    = (((window ^ pattern_q) & mask) == '0);
    assign filled = ((fill_q + 5'd1) >= len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        z         = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (legal_start) state_d = SCAN;
                    else             err_set = 1'b1;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (bus.cfg_we || bus.start) err_set = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    bit_ready = 1'b1;
                    accept    = bus.bit_valid;
                    z         = accept && filled && hit;
                    if (accept && (remain_q == FRAME_W'(1))) begin
                        state_d = DONE;
                    end
`ifdef SEQ_MATCH_TIMEOUT_EN
                    else if (!accept && (stall_q == STALL_W'(TIMEOUT - 1))) begin
                        state_d = IDLE;
                        err_set = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                if (bus.cfg_we || bus.start) err_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            remain_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_set;
            if (state_q == IDLE) begin
                if (bus.cfg_we) begin
                    pattern_q <= bus.cfg_pattern;
                    len_q     <= bus.cfg_len;
                    overlap_q <= bus.cfg_overlap;
                end
                if (bus.start && legal_start) begin
                    hist_q   <= '0;
                    fill_q   <= '0;
                    remain_q <= bus.frame_len;
                    cnt_q    <= '0;
                end
            end
            if (accept) begin
                hist_q   <= window[MAX_LEN-2:0];
                remain_q <= remain_q - FRAME_W'(1);
                if (z && !overlap_q)           fill_q <= '0;
                else if (fill_q != 5'(MAX_LEN)) fill_q <= fill_q + 5'd1;
                if (z && (cnt_q != '1))        cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_MATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          stall_q <= '0;
        else if (state_q != SCAN || accept)  stall_q <= '0;
        else                                 stall_q <= stall_q + STALL_W'(1);
    end
`endif

    assign bus.bit_ready = bit_ready;
    assign bus.z         = z;
    assign bus.match_cnt = cnt_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: directed scenarios plus random frames
// compared against a bit-history reference model.
module tb_seq_match_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int FRAME_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_match_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .FRAME_W(FRAME_W)) bus ();

    seq_match_ctrl #(
        .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .FRAME_W(FRAME_W), .TIMEOUT(64)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the list of bits received in the frame and how many of them
    // are still eligible to take part in a match.
    bit       stim[$];
    bit       hist[$];
    int       m_since, m_cnt, m_len, z_hits;
    bit [7:0] m_pat;
    bit       m_ovl;

    function automatic bit model_z(input bit b);
        if (m_since + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            bit v;
            v = (k == 0) ? b : hist[hist.size() - k];
            if (v != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_accept(input bit b);
        bit zz;
        zz = model_z(b);
        hist.push_back(b);
        m_since++;
        if (zz) begin
            z_hits++;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!m_ovl) m_since = 0;
        end
    endtask

    task automatic begin_frame(input bit [7:0] pat, input int len, input bit ovl, input int flen);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_pattern = pat; bus.cfg_len = 5'(len);
        bus.cfg_overlap = ovl; bus.start = 1'b1; bus.frame_len = 8'(flen);
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        m_pat = pat; m_len = len; m_ovl = ovl; m_cnt = 0; m_since = 0; z_hits = 0;
        hist.delete();
        check("start_busy", bus.busy, 1);
        check("start_cnt_clear", bus.match_cnt, 0);
    endtask

    task automatic feed(input int n, input int gap);
        int target, guard;
        target = hist.size() + n;
        guard  = 0;
        while (hist.size() < target && guard < 2000) begin
            bit v, b, zexp;
            v = ($urandom_range(99) >= gap);
            b = stim[hist.size()];
            bus.bit_valid = v; bus.bit_in = b;
            #1;
            zexp = v ? model_z(b) : 1'b0;
            check("scan_ready", bus.bit_ready, 1);
            check("z", bus.z, zexp);
            @(posedge clk);
            if (v) model_accept(b);
            @(negedge clk);
            bus.bit_valid = 1'b0;
            check("match_cnt", bus.match_cnt, m_cnt);
            guard++;
        end
        check("feed_budget", hist.size(), target);
    endtask

    task automatic end_frame();
        #1;
        check("done_pulse", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_ready", bus.bit_ready, 0);
        check("done_cnt", bus.match_cnt, m_cnt);
        @(negedge clk);
        check("done_single", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_cnt_hold", bus.match_cnt, m_cnt);
    endtask

    task automatic load_stim(input bit [31:0] bits, input int n);
        stim.delete();
        for (int i = n - 1; i >= 0; i--) stim.push_back(bits[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus.start = 0; bus.frame_len = '0; bus.abort = 0; bus.bit_valid = 0; bus.bit_in = 0;
        #2;
        check("rst_ready", bus.bit_ready, 0);
        check("rst_z", bus.z, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_cnt", bus.match_cnt, 0);
        @(negedge clk); rst_n = 1'b1;

        // Overlapping and non-overlapping on the same stream.
        load_stim(32'b111011101, 9);
        begin_frame(8'b11101, 5, 1'b1, 9); feed(9, 0); end_frame();
        check("t1_cnt", bus.match_cnt, 2);
        check("t1_zhits", z_hits, 2);
        begin_frame(8'b11101, 5, 1'b0, 9); feed(9, 0); end_frame();
        check("t2_cnt", bus.match_cnt, 1);

        // Illegal starts: len 0, len > MAX_LEN, frame_len 0.
        for (int i = 0; i < 3; i++) begin
            int lens[3] = '{0, 9, 3};
            int fls[3]  = '{5, 5, 0};
            @(negedge clk);
            bus.cfg_we = 1; bus.cfg_len = 5'(lens[i]); bus.start = 1; bus.frame_len = 8'(fls[i]);
            @(negedge clk);
            bus.cfg_we = 0; bus.start = 0;
            check("bad_err", bus.err, 1);
            check("bad_busy", bus.busy, 0);
            check("bad_cnt_hold", bus.match_cnt, 1);
            @(negedge clk);
            check("bad_err_pulse", bus.err, 0);
            check("bad_busy2", bus.busy, 0);
        end

        // Gapped input, pattern 101.
        load_stim(32'b101011, 6);
        begin_frame(8'b101, 3, 1'b1, 6); feed(6, 40); end_frame();
        check("t4_cnt", bus.match_cnt, 2);

        // Start during scan is rejected, then abort after 4 bits of 9.
        load_stim(32'b101011101, 9);
        begin_frame(8'b101, 3, 1'b1, 9); feed(4, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("scan_start_err", bus.err, 1);
        check("scan_start_busy", bus.busy, 1);
        bus.abort = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = stim[4];
        #1;
        check("abort_z", bus.z, 0);
        check("abort_ready", bus.bit_ready, 0);
        @(negedge clk);
        bus.abort = 1'b0; bus.bit_valid = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_cnt", bus.match_cnt, 1);
        @(negedge clk);
        check("abort_no_done", bus.done, 0);

        // Reset in the middle of a scan.
        load_stim(32'hFF, 8);
        begin_frame(8'b1, 1, 1'b0, 8); feed(2, 0);
        check("pre_rst_cnt", bus.match_cnt, 2);
        rst_n = 1'b0; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
        #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_ready", bus.bit_ready, 0);
        check("mrst_z", bus.z, 0);
        check("mrst_cnt", bus.match_cnt, 0);
        check("mrst_done", bus.done, 0);
        check("mrst_err", bus.err, 0);
        @(negedge clk); rst_n = 1'b1; bus.bit_valid = 1'b0;

        // Counter saturation at 2^CNT_W-1.
        load_stim(32'hFFFFF, 20);
        begin_frame(8'b1, 1, 1'b0, 20); feed(20, 10); end_frame();
        check("sat_cnt", bus.match_cnt, CNT_MAX);

        // Stall for 64 cycles in SCAN.
        load_stim(32'b10110, 5);
        begin_frame(8'b10, 2, 1'b1, 5);
        for (int i = 0; i < 64; i++) begin
            check("stall_busy", bus.busy, 1);
            @(negedge clk);
        end
`ifdef SEQ_MATCH_TIMEOUT_EN
        check("timeout_err", bus.err, 1);
        check("timeout_busy", bus.busy, 0);
        check("timeout_done", bus.done, 0);
`else
        check("no_timeout_busy", bus.busy, 1);
        check("no_timeout_err", bus.err, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("stall_abort_busy", bus.busy, 0);
`endif

        // Random frames.
        for (int f = 0; f < 30; f++) begin
            int len, flen;
            bit [7:0] pat;
            len  = $urandom_range(MAX_LEN, 1);
            flen = $urandom_range(24, 1);
            pat  = 8'($urandom) & 8'((1 << len) - 1);
            stim.delete();
            for (int i = 0; i < flen; i++) begin
                // Bias towards the pattern so long patterns still match sometimes.
                if ($urandom_range(1)) stim.push_back(pat[len - 1 - (i % len)]);
                else                   stim.push_back(1'($urandom));
            end
            begin_frame(pat, len, 1'($urandom), flen);
            feed(flen, 30);
            end_frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
